// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_OFF    : all segments dark (active-high encoding)
//   hex_to_seg : hex nibble -> segments, active-high, order {g,f,e,d,c,b,a}
package sevenseg_pkg;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] s;
      case (hex)
         4'h0:    s = 7'b0111111;
         4'h1:    s = 7'b0000110;
         4'h2:    s = 7'b1011011;
         4'h3:    s = 7'b1001111;
         4'h4:    s = 7'b1100110;
         4'h5:    s = 7'b1101101;
         4'h6:    s = 7'b1111101;
         4'h7:    s = 7'b0000111;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1101111;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b1111100;
         4'hC:    s = 7'b0111001;
         4'hD:    s = 7'b1011110;
         4'hE:    s = 7'b1111001;
         default: s = 7'b1110001; // F
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and flags each rising edge with a
// single-cycle pulse. All flops reset to 1 so that a source which is itself
// high out of reset produces no edge when reset is released.
//   clk   : system clock
//   reset : asynchronous, active-high
//   d     : asynchronous input level
//   rise  : one clk-cycle pulse per rising edge of d
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   // High for exactly one cycle no matter how long d stays high.
   assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexes NUM_DIGITS hex digits onto a shared seven-segment bus, stepping
// one digit per rising edge of the (asynchronous) divided scan clock. Display
// data is captured as a whole-frame snapshot when the scan wraps to digit 0,
// so a value is never shown half old, half new.
//   clk, reset   : system clock, asynchronous active-high reset
//   scan_clk_in  : divided scan clock (async)
//   value        : hex nibbles, digit 0 = value[3:0]
//   dp_in        : decimal point per digit
//   blank_in     : 1 = digit forced dark
//   lz_suppress  : 1 = leading zero digits dark
//   an, seg, dp  : registered anode enables / segments {g..a} / decimal point
//   frame_start  : one-cycle pulse in the cycle a new snapshot is held
module sevenseg_scan_driver
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SYNC_STAGES = 2,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    scan_clk_in,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_suppress,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_POL    = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};

   logic                    tick;
   logic                    wrap;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    tick_q;
   logic                    frame_start_q;
   logic [4*NUM_DIGITS-1:0] value_q;
   logic [NUM_DIGITS-1:0]   dp_q, blank_q;
   logic                    lz_q;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q_out, dp_d;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_scan_edge (
      .clk   (clk),
      .reset (reset),
      .d     (scan_clk_in),
      .rise  (tick)
   );

   assign wrap = (idx_q == LAST_IDX);

   always_comb begin
      idx_d = idx_q;
      if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
   end

   // Index, snapshot and the delayed tick that loads the output register.
   // Starting at the last digit makes the very first tick wrap and snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q         <= LAST_IDX;
         tick_q        <= 1'b0;
         frame_start_q <= 1'b0;
         value_q       <= '0;
         dp_q          <= '0;
         blank_q       <= '0;
         lz_q          <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         tick_q        <= tick;
         frame_start_q <= tick & wrap;
         if (tick && wrap) begin
            value_q <= value;
            dp_q    <= dp_in;
            blank_q <= blank_in;
            lz_q    <= lz_suppress;
         end
      end
   end

   // Next output word for the current digit, built from the snapshot only.
   always_comb begin
      logic                  zero_run;
      logic [NUM_DIGITS-1:0] lz_dark;
      logic [NUM_DIGITS-1:0] an_hi;
      logic [3:0]            cur_nib;
      logic                  cur_blank, cur_lz, cur_dp, lit;

      // Walk from the most significant digit down; a digit is leading-zero
      // dark while every nibble at or above it is zero. Digit 0 never is.
      zero_run = 1'b1;
      lz_dark  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run & (value_q[4*i +: 4] == 4'h0);
         lz_dark[i] = (i != 0) && lz_q && zero_run;
      end

      cur_nib   = value_q[{idx_q, 2'b00} +: 4];
      cur_blank = blank_q[idx_q];
      cur_lz    = lz_dark[idx_q];
      cur_dp    = dp_q[idx_q];
      lit       = ~cur_blank & ~cur_lz;

      // An lz-dark digit keeps its anode on only to show a requested dp.
      an_hi        = '0;
      an_hi[idx_q] = ~cur_blank & (~cur_lz | cur_dp);

      an_d  = an_hi ^ AN_POL;
      seg_d = (lit ? hex_to_seg(cur_nib) : SEG_OFF) ^ SEG_POL;
      dp_d  = (~cur_blank & cur_dp) ^ ACTIVE_LOW;
   end

   // Loaded one cycle after the tick, once idx and the snapshot have settled;
   // holds otherwise, so nothing lights between reset and the first edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q     <= AN_POL;
         seg_q    <= SEG_POL;
         dp_q_out <= ACTIVE_LOW;
      end else if (tick_q) begin
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q_out <= dp_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q_out;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver (NUM_DIGITS=4, ACTIVE_LOW=1).
module tb_sevenseg_scan_driver;

   localparam logic [6:0] OFF = 7'b1111111;
   localparam int LAT = 4;   // SYNC_STAGES + 2

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        scan_clk_in;
   logic [15:0] value;
   logic [3:0]  dp_in, blank_in;
   logic        lz_suppress;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_start;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   sevenseg_scan_driver #(.NUM_DIGITS(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .scan_clk_in (scan_clk_in),
      .value       (value),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lz_suppress (lz_suppress),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_start (frame_start)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int fs_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [11:0] exp_q[$];   // {an, seg, dp}
   int          due_q[$];

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_start) fs_count++;
         n_checks++;
         if (!$onehot0(~an)) begin
            n_fail++;
            $display("FAIL an_onehot: got %b expected at most one low bit (cycle %0d)", an, cyc);
         end
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            logic [11:0] e;
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("scan_out", 32'({an, seg, dp}), 32'(e));
         end
      end
   end

   // One model-divider period: low, then rising edge with expected output pushed.
   task automatic scan_edge(input logic [11:0] e);
      scan_clk_in = 1'b0;
      repeat (6) @(negedge clk);
      scan_clk_in = 1'b1;
      exp_q.push_back(e);
      due_q.push_back(cyc + LAT);
      repeat (6) @(negedge clk);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string            name;
      logic [15:0]      value;
      logic [3:0]       dp_in;
      logic [3:0]       blank;
      logic             lz;
      logic [3:0][3:0]  exp_an;   // {d3,d2,d1,d0}
      logic [3:0][6:0]  exp_seg;
      logic [3:0]       exp_dp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{"basic_12AF", 16'h12AF, 4'b0000, 4'b0000, 1'b0,
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
      vecs[1] = '{"lz_0005", 16'h0005, 4'b0000, 4'b0000, 1'b1,
                  {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                  {OFF, OFF, OFF, 7'b0010010}, 4'b1111};
      vecs[2] = '{"lz_0000", 16'h0000, 4'b0000, 4'b0000, 1'b1,
                  {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                  {OFF, OFF, OFF, 7'b1000000}, 4'b1111};
      vecs[3] = '{"lz_0500", 16'h0500, 4'b0000, 4'b0000, 1'b1,
                  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                  {OFF, 7'b0010010, 7'b1000000, 7'b1000000}, 4'b1111};
      vecs[4] = '{"blank_dp", 16'h12AF, 4'b0110, 4'b0100, 1'b0,
                  {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                  {7'b1111001, OFF, 7'b0001000, 7'b0001110}, 4'b1101};
      vecs[5] = '{"lz_dark_dp", 16'h0007, 4'b1000, 4'b0000, 1'b1,
                  {4'b0111, 4'b1111, 4'b1111, 4'b1110},
                  {OFF, OFF, OFF, 7'b1111000}, 4'b0111};
      vecs[6] = '{"lz_nonzero_top_blank0", 16'h8D3C, 4'b0000, 4'b0001, 1'b1,
                  {4'b0111, 4'b1011, 4'b1101, 4'b1111},
                  {7'b0000000, 7'b0100001, 7'b0110000, OFF}, 4'b1111};
      vecs[7] = '{"lz_inner_zero", 16'h0101, 4'b0000, 4'b0000, 1'b1,
                  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                  {OFF, 7'b1111001, 7'b1000000, 7'b1111001}, 4'b1111};
      vecs[8] = '{"no_lz_0000", 16'h0000, 4'b0000, 4'b0000, 1'b0,
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
   end

   // ---------------- main sequence ----------------
   initial begin
      int fs0;
      int lat;
      int changes;
      int k;
      logic [3:0] an_prev;

      reset       = 1'b1;
      scan_clk_in = 1'b1;   // divider output is high while in reset
      value       = '0;
      dp_in       = '0;
      blank_in    = '0;
      lz_suppress = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", 32'({an, seg, dp, frame_start}), 32'({4'b1111, OFF, 1'b1, 1'b0}));
      reset = 1'b0;

      // Input held high through release: no tick, nothing lights.
      repeat (10) @(negedge clk);
      check("release_no_tick_out", 32'({an, seg, dp}), 32'({4'b1111, OFF, 1'b1}));
      check("release_no_frame", 32'(fs_count), 32'd0);

      // Table: one full frame per vector, inputs changed while digit 3 shows.
      foreach (vecs[v]) begin
         value       = vecs[v].value;
         dp_in       = vecs[v].dp_in;
         blank_in    = vecs[v].blank;
         lz_suppress = vecs[v].lz;
         fs0         = fs_count;
         for (int d = 0; d < 4; d++)
            scan_edge({vecs[v].exp_an[d], vecs[v].exp_seg[d], vecs[v].exp_dp[d]});
         check({"frame_start_", vecs[v].name}, 32'(fs_count), 32'(fs0 + 1));
      end

      // Anti-tear: change value after the digit-1 tick.
      value = 16'h1234; dp_in = '0; blank_in = '0; lz_suppress = 1'b0;
      scan_edge({4'b1110, 7'b0011001, 1'b1});   // 4
      scan_edge({4'b1101, 7'b0110000, 1'b1});   // 3
      value = 16'h5678;
      scan_edge({4'b1011, 7'b0100100, 1'b1});   // still 2
      scan_edge({4'b0111, 7'b1111001, 1'b1});   // still 1
      scan_edge({4'b1110, 7'b0000000, 1'b1});   // 8
      scan_edge({4'b1101, 7'b1111000, 1'b1});   // 7
      scan_edge({4'b1011, 7'b0000010, 1'b1});   // 6
      scan_edge({4'b0111, 7'b0010010, 1'b1});   // 5

      // Latency and long-high hold.
      value = 16'h12AF;
      scan_clk_in = 1'b0;
      repeat (6) @(negedge clk);
      an_prev = an;
      scan_clk_in = 1'b1;
      exp_q.push_back({4'b1110, 7'b0001110, 1'b1});
      due_q.push_back(cyc + LAT);
      lat = 0;
      while (lat < 50) begin
         @(negedge clk);
         lat++;
         if (an !== an_prev) break;
      end
      check("edge_to_an_latency", 32'(lat), 32'(LAT));
      an_prev = an;
      changes = 0;
      repeat (1000) begin
         @(negedge clk);
         if (an !== an_prev) begin
            changes++;
            an_prev = an;
         end
      end
      check("hold_high_no_extra_advance", 32'(changes), 32'd0);
      check("hold_high_an", 32'(an), 32'(4'b1110));

      // Advance to digit 2, then reset mid-frame.
      scan_edge({4'b1101, 7'b0001000, 1'b1});
      scan_edge({4'b1011, 7'b0100100, 1'b1});
      reset = 1'b1;
      #1;
      check("mid_reset_out", 32'({an, seg, dp, frame_start}), 32'({4'b1111, OFF, 1'b1, 1'b0}));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      fs0 = fs_count;
      repeat (20) @(negedge clk);
      check("post_reset_held_high_out", 32'({an, seg, dp}), 32'({4'b1111, OFF, 1'b1}));
      check("post_reset_held_high_frame", 32'(fs_count), 32'(fs0));

      // First edge after reset wraps to digit 0 and snapshots.
      scan_clk_in = 1'b0;
      repeat (6) @(negedge clk);
      scan_clk_in = 1'b1;
      k = cyc;
      exp_q.push_back({4'b1110, 7'b0001110, 1'b1});
      due_q.push_back(k + LAT);
      repeat (2) @(negedge clk);
      check("frame_start_early", 32'(frame_start), 32'd0);
      @(negedge clk);
      check("frame_start_first_edge", 32'(frame_start), 32'd1);
      @(negedge clk);
      check("frame_start_one_cycle", 32'(frame_start), 32'd0);
      repeat (6) @(negedge clk);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
